// File: rtl/perm_seq_player_pkg.sv
// Purpose: shared constants, FSM state type and nibble-select helper for perm_seq_player.
// Latency: n/a (declarations and a combinational helper only).
// Backpressure: n/a.
package perm_seq_player_pkg;

    localparam int PERM_N    = 16;
    localparam int PERM_W    = 4;
    localparam int PERM_BITS = PERM_N * PERM_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    // Element 0 lives in the top nibble, so element idx sits (15-idx) nibbles
    // above bit 0. ~idx is exactly 15-idx for a 4-bit index, and {.., 2'b00}
    // multiplies it by the 4-bit nibble width.
    function automatic logic [PERM_W-1:0] nibble_sel(
        input logic [PERM_BITS-1:0] v,
        input logic [PERM_W-1:0]    idx
    );
        logic [PERM_BITS-1:0] sh;
        sh = v >> {~idx, 2'b00};
        return sh[PERM_W-1:0];
    endfunction

endpackage

// File: rtl/perm_seq_player_check.sv
// Purpose: flags whether a packed 16x4-bit word holds every value 0..15 exactly once.
// Latency: purely combinational.
// Backpressure: none.
// Ports: seq - packed candidate permutation; is_perm - 1 when all 16 values are present.
module perm_check
    import perm_seq_player_pkg::*;
(
    input  logic [PERM_BITS-1:0] seq,
    output logic                 is_perm
);

    logic [PERM_N-1:0] seen;

    // With 16 nibbles and 16 possible values, "all values seen" also
    // rules out duplicates, so a full mask is a complete check.
    always_comb begin
        seen = '0;
        for (int k = 0; k < PERM_N; k++) begin
            seen = seen | (PERM_N'(1) << seq[k*PERM_W +: PERM_W]);
        end
    end

    assign is_perm = &seen;

endmodule

// File: rtl/perm_seq_player.sv
// Purpose: capture a packed 0..15 permutation, verify it, and stream it out one nibble per transfer.
// Latency: load in cycle N -> element 0 valid in N+1; done pulses the cycle after element 15 is taken.
// Backpressure: out_ready low stalls the current element (data/last held); GAP forces idle cycles between transfers.
// Ports: clk, rst (sync, active-high); seq_all/load capture request; out_valid/out_ready/out_data/out_last
//        element stream; busy while playing; done one-cycle pulse; perm_err sticky bad-capture flag.
module perm_seq_player
    import perm_seq_player_pkg::*;
#(
    parameter int GAP = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PERM_BITS-1:0] seq_all,
    input  logic                 load,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [PERM_W-1:0]    out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done,
    output logic                 perm_err
);

    localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [PERM_W-1:0] IDX_LAST = PERM_W'(PERM_N - 1);

    state_t               state_q;
    logic [PERM_BITS-1:0] buf_q;
    logic [PERM_W-1:0]    idx_q;
    logic [GAP_W-1:0]     gap_q;
    logic                 done_q;
    logic                 perm_err_q;
    logic                 seq_is_perm;
    logic                 xfer;

    perm_check u_check (
        .seq     (seq_all),
        .is_perm (seq_is_perm)
    );

    // Stream outputs depend only on registered state, never on out_ready or seq_all.
    assign out_valid = (state_q == ST_PLAY) && (gap_q == '0);
    assign out_data  = out_valid ? nibble_sel(buf_q, idx_q) : '0;
    assign out_last  = out_valid && (idx_q == IDX_LAST);
    assign busy      = (state_q == ST_PLAY);
    assign done      = done_q;
    assign perm_err  = perm_err_q;

    assign xfer = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            buf_q      <= '0;
            idx_q      <= '0;
            gap_q      <= '0;
            done_q     <= 1'b0;
            perm_err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        // Captured unconditionally; on a bad sequence the buffer
                        // is never played, so its contents do not matter.
                        buf_q <= seq_all;
                        if (seq_is_perm) begin
                            state_q    <= ST_PLAY;
                            idx_q      <= '0;
                            gap_q      <= '0;
                            perm_err_q <= 1'b0;
                        end else begin
                            perm_err_q <= 1'b1;
                        end
                    end
                end
                ST_PLAY: begin
                    // load is deliberately ignored here so the buffer stays stable.
                    if (xfer) begin
                        if (idx_q == IDX_LAST) begin
                            state_q <= ST_IDLE;
                            idx_q   <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + PERM_W'(1);
                            gap_q <= GAP_W'(GAP);
                        end
                    end else if (gap_q != '0) begin
                        gap_q <= gap_q - GAP_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_perm_seq_player.sv
module tb_perm_seq_player;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] seq_all;
    logic        load;
    logic        out_ready;

    logic       o0_valid, o0_last, o0_busy, o0_done, o0_err;
    logic [3:0] o0_data;
    logic       o2_valid, o2_last, o2_busy, o2_done, o2_err;
    logic [3:0] o2_data;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: per instance (0 -> GAP=0, 1 -> GAP=2) the captured list,
    // the position being offered and the remaining forced-idle cycles.
    bit m_play [2];
    int m_pos  [2];
    int m_wait [2];
    bit m_done [2];
    bit m_err  [2];
    int m_seq  [2][16];

    int acc0[$];
    int acc2[$];

    perm_seq_player #(.GAP(0)) u_g0 (
        .clk(clk), .rst(rst), .seq_all(seq_all), .load(load), .out_ready(out_ready),
        .out_valid(o0_valid), .out_data(o0_data), .out_last(o0_last),
        .busy(o0_busy), .done(o0_done), .perm_err(o0_err)
    );

    perm_seq_player #(.GAP(2)) u_g2 (
        .clk(clk), .rst(rst), .seq_all(seq_all), .load(load), .out_ready(out_ready),
        .out_valid(o2_valid), .out_data(o2_data), .out_last(o2_last),
        .busy(o2_busy), .done(o2_done), .perm_err(o2_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int nib(input logic [63:0] v, input int i);
        return int'(v[63-4*i -: 4]);
    endfunction

    // Counts occurrences of each value; a permutation has every count equal to one.
    function automatic bit model_is_perm(input logic [63:0] v);
        int cnt[16];
        foreach (cnt[i]) cnt[i] = 0;
        for (int i = 0; i < 16; i++) cnt[nib(v, i)]++;
        foreach (cnt[i]) if (cnt[i] != 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [63:0] rand_perm();
        int a[16];
        int j, t;
        logic [63:0] v;
        for (int i = 0; i < 16; i++) a[i] = i;
        for (int i = 15; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = a[i]; a[i] = a[j]; a[j] = t;
        end
        v = '0;
        for (int i = 0; i < 16; i++) v[63-4*i -: 4] = 4'(a[i]);
        return v;
    endfunction

    task automatic model_step();
        bit offered;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_play[k] = 0; m_pos[k] = 0; m_wait[k] = 0; m_done[k] = 0; m_err[k] = 0;
            end else begin
                offered   = m_play[k] && (m_wait[k] == 0);
                m_done[k] = 0;
                if (!m_play[k]) begin
                    if (load) begin
                        if (model_is_perm(seq_all)) begin
                            for (int i = 0; i < 16; i++) m_seq[k][i] = nib(seq_all, i);
                            m_play[k] = 1; m_pos[k] = 0; m_wait[k] = 0; m_err[k] = 0;
                        end else begin
                            m_err[k] = 1;
                        end
                    end
                end else if (offered && out_ready) begin
                    if (m_pos[k] == 15) begin
                        m_play[k] = 0; m_pos[k] = 0; m_done[k] = 1;
                    end else begin
                        m_pos[k]++;
                        m_wait[k] = (k == 0) ? 0 : 2;
                    end
                end else if (m_wait[k] > 0) begin
                    m_wait[k]--;
                end
            end
        end
    endtask

    task automatic check_inst(input int k, input logic v, input logic [3:0] d, input logic l,
                              input logic b, input logic dn, input logic e);
        string p;
        bit    ev;
        p  = (k == 0) ? "g0" : "g2";
        ev = m_play[k] && (m_wait[k] == 0);
        chk({p, "_valid"}, int'(v), int'(ev));
        chk({p, "_data"}, int'(d), ev ? m_seq[k][m_pos[k]] : 0);
        chk({p, "_last"}, int'(l), int'(ev && (m_pos[k] == 15)));
        chk({p, "_busy"}, int'(b), int'(m_play[k]));
        chk({p, "_done"}, int'(dn), int'(m_done[k]));
        chk({p, "_perm_err"}, int'(e), int'(m_err[k]));
    endtask

    // One clock: log transfers seen before the edge, advance the model, check after the edge.
    task automatic cycle();
        if (!rst && o0_valid && out_ready) acc0.push_back(int'(o0_data));
        if (!rst && o2_valid && out_ready) acc2.push_back(int'(o2_data));
        @(posedge clk);
        model_step();
        #1;
        check_inst(0, o0_valid, o0_data, o0_last, o0_busy, o0_done, o0_err);
        check_inst(1, o2_valid, o2_data, o2_last, o2_busy, o2_done, o2_err);
    endtask

    // Caller sets load/seq_all for the first cycle. mode: 0 ready high, 1 ready 1,0,0 repeating, 2 random.
    task automatic play(input int inst, input int mode, input int budget, output int cyc);
        bit got;
        got = 0;
        cyc = 0;
        for (int i = 0; i < budget && !got; i++) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((i % 3) == 1);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            cycle();
            cyc++;
            got  = (inst == 0) ? o0_done : o2_done;
            load = 1'b0;
        end
        chk("done_within_budget", int'(got), 1);
    endtask

    task automatic cmp_stream(input string tag, input int q[$], input logic [63:0] v);
        chk({tag, "_count"}, q.size(), 16);
        for (int i = 0; i < 16 && i < q.size(); i++) chk({tag, "_elem"}, q[i], nib(v, i));
    endtask

    initial begin
        int          cyc;
        logic [63:0] p, q, r;
        bit          hit;

        rst = 1'b1; load = 1'b0; out_ready = 1'b0; seq_all = '0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // Full descending permutation, ready held high: 16 back-to-back elements, done at N+17.
        acc0.delete();
        seq_all = 64'hFEDCBA9876543210;
        load = 1'b1;
        play(0, 0, 40, cyc);
        chk("desc_load_to_done", cyc, 17);
        chk("desc_count", acc0.size(), 16);
        for (int i = 0; i < 16 && i < acc0.size(); i++) chk("desc_elem", acc0[i], 15 - i);

        // Duplicate 0 / missing F: rejected, flag set, nothing plays.
        for (int i = 0; i < 4; i++) cycle();
        seq_all = 64'h0123456789ABCDE0;
        load = 1'b1;
        cycle();
        load = 1'b0;
        cycle();
        chk("bad_perm_err", int'(o0_err), 1);
        chk("bad_no_busy", int'(o0_busy), 0);
        chk("bad_no_valid", int'(o0_valid), 0);
        for (int i = 0; i < 30; i++) cycle();

        // A good load clears the flag; random backpressure.
        acc0.delete();
        p = rand_perm();
        seq_all = p;
        load = 1'b1;
        play(0, 2, 200, cyc);
        cmp_stream("recover", acc0, p);
        chk("recover_err_clear", int'(o0_err), 0);

        // Ready pattern with stalls: exactly 0..15, no loss or duplication.
        for (int i = 0; i < 40; i++) cycle();
        acc0.delete();
        seq_all = 64'h0123456789ABCDEF;
        load = 1'b1;
        play(0, 1, 200, cyc);
        for (int i = 0; i < 16 && i < acc0.size(); i++) chk("bp_elem", acc0[i], i);
        chk("bp_count", acc0.size(), 16);

        // Loads during playback (element 5 and the final handshake) are ignored.
        for (int i = 0; i < 40; i++) cycle();
        acc0.delete();
        p = rand_perm();
        q = rand_perm();
        seq_all = p;
        load = 1'b1;
        cycle();
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (o0_valid && (acc0.size() == 5 || acc0.size() == 15)) begin
                load = 1'b1; seq_all = q; out_ready = 1'b1;
            end else begin
                load = 1'b0; out_ready = 1'($urandom_range(0, 1));
            end
            cycle();
            hit = o0_done;
        end
        chk("midload_done", int'(hit), 1);
        cmp_stream("midload", acc0, p);
        acc0.delete();
        seq_all = q;
        load = 1'b1;
        play(0, 0, 40, cyc);
        chk("after_done_load_to_done", cyc, 17);
        cmp_stream("after_done", acc0, q);

        // Reset while element 7 is presented (coincident handshake).
        for (int i = 0; i < 40; i++) cycle();
        acc0.delete();
        p = rand_perm();
        seq_all = p;
        load = 1'b1;
        out_ready = 1'b1;
        cycle();
        load = 1'b0;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (o0_valid && acc0.size() == 7) hit = 1;
            else cycle();
        end
        chk("rst_reached_elem7", int'(hit), 1);
        chk("rst_elem7_data", int'(o0_data), nib(p, 7));
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_valid", int'(o0_valid), 0);
        chk("rst_data", int'(o0_data), 0);
        chk("rst_busy", int'(o0_busy), 0);
        chk("rst_g2_busy", int'(o2_busy), 0);
        acc0.delete();
        acc2.delete();
        r = rand_perm();
        seq_all = r;
        load = 1'b1;
        play(0, 0, 40, cyc);
        cmp_stream("post_rst", acc0, r);

        // GAP=2 instance: valid 1,0,0,... ; 16 elements over 46 cycles, done one later.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        acc2.delete();
        p = rand_perm();
        seq_all = p;
        load = 1'b1;
        play(1, 0, 80, cyc);
        chk("gap2_load_to_done", cyc, 47);
        cmp_stream("gap2", acc2, p);

        // Random rounds mixing good and corrupted sequences under random ready.
        for (int round = 0; round < 6; round++) begin
            for (int i = 0; i < 50; i++) cycle();
            p = rand_perm();
            if ($urandom_range(0, 2) == 0) p[3:0] = p[7:4];
            acc0.delete();
            seq_all = p;
            load = 1'b1;
            if (model_is_perm(p)) begin
                play(0, 2, 300, cyc);
                cmp_stream("rand", acc0, p);
            end else begin
                cycle();
                load = 1'b0;
                cycle();
                chk("rand_bad_err", int'(o0_err), 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/perm_seq_player.md
# perm_seq_player

Downstream consumer of the 16-entry random permutation generator. Captures a 64-bit packed permutation of 0..15 on request and checks it is a true permutation. Plays it out one 4-bit element at a time over a valid/ready stream, then pulses `done` so the upstream generator can be asked for the next sequence.

## Interface
- `GAP`, default 0: idle cycles forced between consecutive accepted elements; 0 allows back-to-back transfers.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `seq_all`  in  64  packed permutation; element 0 is `[63:60]`, element 15 is `[3:0]`.
- `load`  in  1  capture request; honoured only in IDLE.
- `out_ready`  in  1  consumer ready.
- `out_valid`  out  1  `out_data` is valid.
- `out_data`  out  4  current element; 0 whenever `out_valid` is 0.
- `out_last`  out  1  high with element 15 only, qualified by `out_valid`.
- `busy`  out  1  high while in PLAY.
- `done`  out  1  one-cycle pulse after element 15 is accepted.
- `perm_err`  out  1  sticky; last `load` captured a non-permutation.

## Operation
- Registers:
  - 64-bit capture buffer
  - 4-bit index `idx`
  - gap counter, width `$clog2(GAP+1)`, minimum 1
  - state: IDLE or PLAY
- Reset, synchronous:
  - state IDLE; `idx`=0; buffer=0; gap counter=0.
  - `out_valid`, `out_data`, `out_last`, `busy`, `done`, `perm_err` all 0.
- IDLE with `load`=1:
  - Capture `seq_all` and evaluate the permutation check on `seq_all` in the same cycle.
  - Valid permutation: enter PLAY, `idx`=0, `perm_err`=0.
  - Invalid: stay IDLE, `perm_err`=1, buffer contents irrelevant.
- PLAY:
  - `out_valid`=1 when the gap counter is 0.
  - `out_data` = buffer nibble at `[63-4*idx -: 4]`.
  - Handshake occurs when `out_valid && out_ready`. On handshake with `idx`<15: `idx`+1, gap counter loads `GAP`.
  - Gap counter decrements while non-zero; `out_valid`=0 during the gap.
  - Handshake with `idx`=15: go to IDLE, `idx`=0, `done`=1 in the next cycle.
- `load` during PLAY is ignored; the buffer stays stable.
  - `load` in the same cycle as the final handshake is ignored. It is accepted in the following cycle, which is IDLE.
- `out_valid` does not drop before its handshake, except on reset. `out_data` and `out_last` are held stable while stalled.
- Permutation check: OR together one-hot decodes of all 16 nibbles into a 16-bit mask; valid iff mask == 16'hFFFF.
- `perm_err` is cleared only by reset or by a successful load.

## Timing
- `load` accepted in cycle N → `busy`=1, `out_valid`=1, element 0 driven in N+1.
- With GAP=0 and `out_ready` held high: 16 elements in cycles N+1..N+16, `done` in N+17, next `load` accepted in N+17.
- With GAP=g: each element is accepted at the earliest g+1 cycles after the previous one.
- `done` and `perm_err` are registered outputs.
- `out_valid`, `out_data` and `out_last` are decoded from registers only; no combinational path from `out_ready` or `seq_all` to any output.
- `rst` in any cycle, including mid-PLAY or coincident with `load` or a handshake, has priority. All outputs are at reset values in the next cycle.

## Structure
- Shared package/header:
  - `PERM_N`=16, `PERM_W`=4, `PERM_BITS`=64
  - state encodings `ST_IDLE`, `ST_PLAY`
  - nibble-select helper
- Sub-module `perm_check`: combinational, 64-bit in, 1-bit `is_perm` out. Reusable by the generator's self-check.
- Top: FSM, index/gap counters, buffer, output decode.

## Test plan
- Reset, `seq_all`=64'hFEDCBA9876543210, pulse `load`, `out_ready`=1:
  - `out_data` = 15,14,…,0 on 16 consecutive cycles.
  - `out_last` only with 0; `done` one cycle later; `busy` falls.
- `seq_all`=64'h0123456789ABCDE0 (duplicate 0, missing F), `load`:
  - `perm_err`=1; `out_valid` and `busy` stay 0.
  - A following load of a valid permutation clears `perm_err`.
- Backpressure with 64'h0123456789ABCDEF: toggle `out_ready` 1,0,0,1,…
  - Data holds while stalled; sequence emitted exactly 0..15, no loss or duplication.
- `load` with a different valid `seq_all` asserted at element 5 and at the final handshake:
  - Both ignored; playback unchanged; next-cycle load after `done` accepted.
- `rst` asserted while element 7 is presented:
  - Next cycle all outputs 0.
  - A new `load` restarts at element 0 of the new buffer.
- GAP=2 instance, `out_ready`=1:
  - `out_valid` pattern 1,0,0,1,0,0,…; 16 elements in 46 cycles.
